vram_bus_arbiter: RTL and testbench
===================================

// Module: vram_bus_arbiter
// PURPOSE
//  Slot-based arbiter for the shared video memory bus (VRAM/VMEM) between the video fetch engine
//  (playfield/motion-object/alpha address generators) and the 68000 CPU port. One access is
//  granted per memory slot; video has priority, with a starvation guard for the CPU. Generates the
//  68000 DTACK_b handshake and the memory chip-select, byte-write and address/data muxing.
// PARAMETERS
//  AW          18  memory word-address width
//  DW          16  data width
//  MEM_LAT     1   clk cycles from slot issue to mem_rdata valid (1..3)
//  STARVE_MAX  8   consecutive slots a pending CPU request may lose before it is forced a slot
// PORTS
//  clk            in   1   system clock, all logic on posedge
//  rst_b          in   1   synchronous reset, active low
//  slot_en        in   1   one-cycle strobe marking the start of a memory slot
//  vid_req        in   1   video fetch wants this slot (sampled on slot_en)
//  vid_addr       in   AW  video fetch address
//  vid_gnt        out  1   one-cycle pulse: video access issued this slot
//  vid_rvld       out  1   one-cycle pulse: rdata holds video read data
//  rdata          out  DW  registered read data (video or CPU)
//  cpu_req        in   1   CPU cycle active (AS asserted and address decoded to VRAM)
//  cpu_we         in   1   1 = write, 0 = read (~R/W)
//  cpu_be         in   2   byte enables {UDS, LDS}, active high
//  cpu_addr       in   AW  CPU word address
//  cpu_wdata      in   DW  CPU write data
//  cpu_dtack_b    out  1   68000 DTACK, active low
//  mem_cs_b       out  1   memory select, active low, asserted one cycle per issued access
//  mem_we_b       out  2   byte write strobes {hi, lo}, active low, valid with mem_cs_b
//  mem_addr       out  AW  memory address
//  mem_wdata      out  DW  memory write data
//  mem_rdata      in   DW  memory read data, valid MEM_LAT cycles after mem_cs_b
//  slot_ovr       out  1   one-cycle pulse: slot_en arrived while a read was still in flight
// BEHAVIOUR
//  Reset (rst_b=0 at posedge): all outputs inactive: vid_gnt=0, vid_rvld=0, rdata=0, cpu_dtack_b=1,
//   mem_cs_b=1, mem_we_b=2'b11, mem_addr=0, mem_wdata=0, slot_ovr=0; CPU FSM -> C_IDLE;
//   starve counter=0; any in-flight read discarded (no vid_rvld / DTACK follows).
//  Slot decision (on slot_en, no read in flight): cpu_pend = (FSM==C_PEND).
//   vid_req & ~(cpu_pend & starve==STARVE_MAX) -> video; else cpu_pend -> CPU; else idle slot.
//   Issue cycle = cycle after slot_en: mem_cs_b=0 for exactly one cycle with winner's addr.
//   vid_gnt pulses in the issue cycle. Video accesses are reads (mem_we_b=11).
//  Starve counter: +1 on each slot_en where cpu_pend and video won (saturates at STARVE_MAX);
//   cleared when CPU is granted or FSM leaves C_PEND.
//  Read return: tracked by a MEM_LAT-deep issue pipe tagged vid/cpu; rdata registered from
//   mem_rdata MEM_LAT cycles after issue; vid_rvld pulses same cycle rdata updates for video tag.
//  CPU FSM:
//   C_IDLE  : cpu_req=1 -> C_PEND.
//   C_PEND  : cpu_req=0 -> C_IDLE (aborted, no access). Granted -> C_BUSY.
//   C_BUSY  : write: issue cycle drives mem_wdata=cpu_wdata, mem_we_b=~cpu_be; -> C_ACK next cycle.
//             read: wait MEM_LAT, rdata<=mem_rdata -> C_ACK. cpu_req drop here: access completes,
//             -> C_IDLE without DTACK.
//   C_ACK   : cpu_dtack_b=0, held while cpu_req=1; cpu_req=0 -> cpu_dtack_b=1, C_IDLE.
//   Video slots continue to be granted while CPU sits in C_ACK; rdata is not overwritten by video
//   returns while in C_ACK for a CPU read (video data then presented via vid_rvld one cycle later,
//   buffered in a one-entry holding register).
//  cpu_be=00 write: treated as completed access, mem_we_b stays 11, DTACK still returned.
//  slot_en while a read is in flight: slot dropped, slot_ovr pulses, no grant; integrator must
//   space slot_en >= MEM_LAT+1 cycles.
//  Address/data outputs hold last issued value between accesses.
// TESTING
//  Video only: vid_req=1, slot_en every 4 clk, mem_rdata=addr -> vid_gnt each slot, vid_rvld
//   MEM_LAT+1 cycles after slot_en, rdata==vid_addr, cpu_dtack_b stays 1.
//  CPU write idle bus: cpu_req=1,we=1,be=10,addr=0x1234,wdata=0xBEEF -> mem_we_b=01 one cycle at
//   0x1234, cpu_dtack_b=0 next cycle, returns to 1 cycle after cpu_req=0.
//  Starvation: vid_req held 1, CPU read pending -> video wins 8 slots, 9th slot to CPU, then
//   DTACK with rdata==mem value at cpu_addr; counter resets to 0.
//  Abort: cpu_req pulses 1 for 2 cycles while video owns slots -> no CPU mem_cs_b, no DTACK.
//  Overrun: MEM_LAT=3, slot_en spacing 2 -> slot_ovr pulses, no second mem_cs_b in flight window.
//  Reset mid CPU read (rst_b=0 during C_BUSY) -> next cycle all outputs at reset values, no
//   DTACK, no vid_rvld; new cpu_req after reset served normally.

Source files
------------

// File: rtl/vram_bus_arbiter.sv
// Slot arbiter for the shared video memory bus: video fetch has priority, the 68000 port
// gets a forced slot after STARVE_MAX lost slots. Drives DTACK_b, chip select and muxes.
module vram_bus_arbiter #(
  parameter int AW         = 18,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          slot_en,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_rvld,
  output logic [DW-1:0] rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_dtack_b,
  output logic          mem_cs_b,
  output logic [1:0]    mem_we_b,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          slot_ovr
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {C_IDLE, C_PEND, C_BUSY, C_ACK} cstate_e;

  cstate_e         state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [MEM_LAT:1] rd_vld_q, rd_vid_q;
  logic            cpu_wr_q;
  logic [DW-1:0]   hold_q;
  logic            hold_vld_q;

  logic            vid_gnt_q, vid_rvld_q, mem_cs_b_q, slot_ovr_q;
  logic [DW-1:0]   rdata_q, mem_wdata_q;
  logic [1:0]      mem_we_b_q;
  logic [AW-1:0]   mem_addr_q;

  logic in_flight, slot_ok, cpu_pend, starved;
  logic vid_win, cpu_win, issue_rd;
  logic ret_vid, ret_cpu, blk;

  // Only reads occupy the return pipe; a write never blocks the next slot.
  always_comb begin
    in_flight = |rd_vld_q;
    slot_ok   = slot_en & ~in_flight;
    cpu_pend  = (state_q == C_PEND) & cpu_req;
    starved   = cpu_pend & (starve_q == SW'(STARVE_MAX));
    vid_win   = slot_ok & vid_req & ~starved;
    cpu_win   = slot_ok & ~vid_win & cpu_pend;
    issue_rd  = vid_win | (cpu_win & ~cpu_we);
    ret_vid   = rd_vld_q[MEM_LAT] & rd_vid_q[MEM_LAT];
    ret_cpu   = rd_vld_q[MEM_LAT] & ~rd_vid_q[MEM_LAT];
    // CPU read data must stay on rdata while DTACK is asserted
    blk       = (state_q == C_ACK) & ~cpu_wr_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE: if (cpu_req) state_d = C_PEND;
      C_PEND: begin
        if (!cpu_req)     state_d = C_IDLE;
        else if (cpu_win) state_d = C_BUSY;
      end
      C_BUSY: if (cpu_wr_q || ret_cpu) state_d = cpu_req ? C_ACK : C_IDLE;
      C_ACK:  if (!cpu_req) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (state_q != C_PEND || cpu_win)
      starve_d = '0;
    else if (vid_win && starve_q < SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= C_IDLE;
      starve_q    <= '0;
      rd_vld_q    <= '0;
      rd_vid_q    <= '0;
      cpu_wr_q    <= 1'b0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      vid_gnt_q   <= 1'b0;
      vid_rvld_q  <= 1'b0;
      rdata_q     <= '0;
      mem_cs_b_q  <= 1'b1;
      mem_we_b_q  <= 2'b11;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      slot_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      vid_gnt_q  <= vid_win;
      mem_cs_b_q <= ~(vid_win | cpu_win);
      mem_we_b_q <= (cpu_win & cpu_we) ? ~cpu_be : 2'b11;
      slot_ovr_q <= slot_en & in_flight;
      if (vid_win)      mem_addr_q <= vid_addr;
      else if (cpu_win) mem_addr_q <= cpu_addr;
      if (cpu_win & cpu_we) mem_wdata_q <= cpu_wdata;
      if (cpu_win)          cpu_wr_q    <= cpu_we;

      for (int i = MEM_LAT; i > 1; i--) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_vid_q[i] <= rd_vid_q[i-1];
      end
      rd_vld_q[1] <= issue_rd;
      rd_vid_q[1] <= vid_win;

      vid_rvld_q <= 1'b0;
      if (ret_cpu) begin
        rdata_q <= mem_rdata;
      end else if (blk) begin
        if (ret_vid) begin
          hold_q     <= mem_rdata;
          hold_vld_q <= 1'b1;
        end
      end else if (hold_vld_q) begin
        // drain the parked video word; a coincident return takes its place
        rdata_q    <= hold_q;
        vid_rvld_q <= 1'b1;
        hold_vld_q <= ret_vid;
        if (ret_vid) hold_q <= mem_rdata;
      end else if (ret_vid) begin
        rdata_q    <= mem_rdata;
        vid_rvld_q <= 1'b1;
      end
    end
  end

  assign vid_gnt     = vid_gnt_q;
  assign vid_rvld    = vid_rvld_q;
  assign rdata       = rdata_q;
  assign cpu_dtack_b = (state_q != C_ACK);
  assign mem_cs_b    = mem_cs_b_q;
  assign mem_we_b    = mem_we_b_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign slot_ovr    = slot_ovr_q;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Directed bench: cycle table for video/CPU basics, hand sequences for starvation,
// abort, reset-mid-read and overrun (second instance with MEM_LAT=3).
module tb_vram_bus_arbiter;

  logic        clk;
  logic        rst_b, slot_en, vid_req, cpu_req, cpu_we;
  logic [17:0] vid_addr, cpu_addr;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_wdata;

  logic        vid_gnt, vid_rvld, cpu_dtack_b, mem_cs_b, slot_ovr;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [1:0]  mem_we_b;
  logic [17:0] mem_addr;

  logic        o_vid_gnt, o_vid_rvld, o_cpu_dtack_b, o_mem_cs_b, o_slot_ovr;
  logic [15:0] o_rdata, o_mem_wdata, o_mem_rdata;
  logic [1:0]  o_mem_we_b;
  logic [17:0] o_mem_addr;

  int n_chk = 0;
  int n_fail = 0;

  // memory returns the low bits of the held address
  assign mem_rdata   = mem_addr[15:0];
  assign o_mem_rdata = o_mem_addr[15:0];

  vram_bus_arbiter #(.AW(18), .DW(16), .MEM_LAT(1), .STARVE_MAX(8)) u_dut (
    .clk(clk), .rst_b(rst_b), .slot_en(slot_en), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(vid_gnt), .vid_rvld(vid_rvld), .rdata(rdata), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_dtack_b(cpu_dtack_b),
    .mem_cs_b(mem_cs_b), .mem_we_b(mem_we_b), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .slot_ovr(slot_ovr));

  vram_bus_arbiter #(.AW(18), .DW(16), .MEM_LAT(3), .STARVE_MAX(8)) u_ovr (
    .clk(clk), .rst_b(rst_b), .slot_en(slot_en), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(o_vid_gnt), .vid_rvld(o_vid_rvld), .rdata(o_rdata), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_dtack_b(o_cpu_dtack_b),
    .mem_cs_b(o_mem_cs_b), .mem_we_b(o_mem_we_b), .mem_addr(o_mem_addr), .mem_wdata(o_mem_wdata),
    .mem_rdata(o_mem_rdata), .slot_ovr(o_slot_ovr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_b, slot_en, vid_req;
    logic [17:0] vid_addr;
    logic        cpu_req, cpu_we;
    logic [1:0]  cpu_be;
    logic [17:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cs_b;
    logic [1:0]  we_b;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic        gnt, rvld;
    logic [15:0] rdata;
    logic        dtack_b;
  } vec_t;

  vec_t vt [29];

  function automatic vec_t mk(input int r, sl, vr, va, cr, cw, cb, ca, cd,
                              input int cs, wb, ad, wd, g, rv, rd, dt);
    vec_t v;
    v.rst_b = 1'(r);  v.slot_en = 1'(sl); v.vid_req = 1'(vr); v.vid_addr = 18'(va);
    v.cpu_req = 1'(cr); v.cpu_we = 1'(cw); v.cpu_be = 2'(cb); v.cpu_addr = 18'(ca);
    v.cpu_wdata = 16'(cd);
    v.cs_b = 1'(cs); v.we_b = 2'(wb); v.addr = 18'(ad); v.wdata = 16'(wd);
    v.gnt = 1'(g); v.rvld = 1'(rv); v.rdata = 16'(rd); v.dtack_b = 1'(dt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    slot_en = 0; vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0;
    cpu_be = 2'b00; cpu_addr = '0; cpu_wdata = '0;
  endtask

  initial begin
    int bad;
    //          rst sl vr va     cr we be   ca       cd       | cs wb ad       wd       g rv rd       dt
    vt[0]  = mk(0, 0, 0, 0,      0, 0, 0,   0,       0,         1, 3, 0,       0,       0, 0, 0,       1);
    vt[1]  = mk(1, 0, 0, 0,      0, 0, 0,   0,       0,         1, 3, 0,       0,       0, 0, 0,       1);
    vt[2]  = mk(1, 1, 1, 'h100,  0, 0, 0,   0,       0,         0, 3, 'h100,   0,       1, 0, 0,       1);
    vt[3]  = mk(1, 0, 1, 'h100,  0, 0, 0,   0,       0,         1, 3, 'h100,   0,       0, 1, 'h100,   1);
    vt[4]  = mk(1, 0, 0, 0,      0, 0, 0,   0,       0,         1, 3, 'h100,   0,       0, 0, 'h100,   1);
    vt[5]  = mk(1, 0, 0, 0,      0, 0, 0,   0,       0,         1, 3, 'h100,   0,       0, 0, 'h100,   1);
    vt[6]  = mk(1, 1, 1, 'h2A5,  0, 0, 0,   0,       0,         0, 3, 'h2A5,   0,       1, 0, 'h100,   1);
    vt[7]  = mk(1, 0, 0, 0,      0, 0, 0,   0,       0,         1, 3, 'h2A5,   0,       0, 1, 'h2A5,   1);
    vt[8]  = mk(1, 0, 0, 0,      0, 0, 0,   0,       0,         1, 3, 'h2A5,   0,       0, 0, 'h2A5,   1);
    vt[9]  = mk(1, 0, 0, 0,      0, 0, 0,   0,       0,         1, 3, 'h2A5,   0,       0, 0, 'h2A5,   1);
    vt[10] = mk(1, 1, 1, 'h3FF,  0, 0, 0,   0,       0,         0, 3, 'h3FF,   0,       1, 0, 'h2A5,   1);
    vt[11] = mk(1, 0, 0, 0,      0, 0, 0,   0,       0,         1, 3, 'h3FF,   0,       0, 1, 'h3FF,   1);
    vt[12] = mk(1, 0, 0, 0,      1, 1, 2,   'h1234,  'hBEEF,    1, 3, 'h3FF,   0,       0, 0, 'h3FF,   1);
    vt[13] = mk(1, 1, 0, 0,      1, 1, 2,   'h1234,  'hBEEF,    0, 1, 'h1234,  'hBEEF,  0, 0, 'h3FF,   1);
    vt[14] = mk(1, 0, 0, 0,      1, 1, 2,   'h1234,  'hBEEF,    1, 3, 'h1234,  'hBEEF,  0, 0, 'h3FF,   0);
    vt[15] = mk(1, 0, 0, 0,      1, 1, 2,   'h1234,  'hBEEF,    1, 3, 'h1234,  'hBEEF,  0, 0, 'h3FF,   0);
    vt[16] = mk(1, 0, 0, 0,      0, 1, 2,   'h1234,  'hBEEF,    1, 3, 'h1234,  'hBEEF,  0, 0, 'h3FF,   1);
    vt[17] = mk(1, 0, 0, 0,      1, 1, 0,   'h55,    'h1111,    1, 3, 'h1234,  'hBEEF,  0, 0, 'h3FF,   1);
    vt[18] = mk(1, 1, 0, 0,      1, 1, 0,   'h55,    'h1111,    0, 3, 'h55,    'h1111,  0, 0, 'h3FF,   1);
    vt[19] = mk(1, 0, 0, 0,      1, 1, 0,   'h55,    'h1111,    1, 3, 'h55,    'h1111,  0, 0, 'h3FF,   0);
    vt[20] = mk(1, 0, 0, 0,      0, 1, 0,   'h55,    'h1111,    1, 3, 'h55,    'h1111,  0, 0, 'h3FF,   1);
    vt[21] = mk(1, 0, 0, 0,      1, 0, 3,   'h777,   0,         1, 3, 'h55,    'h1111,  0, 0, 'h3FF,   1);
    vt[22] = mk(1, 1, 0, 0,      1, 0, 3,   'h777,   0,         0, 3, 'h777,   'h1111,  0, 0, 'h3FF,   1);
    vt[23] = mk(1, 0, 0, 0,      1, 0, 3,   'h777,   0,         1, 3, 'h777,   'h1111,  0, 0, 'h777,   0);
    vt[24] = mk(1, 1, 1, 'hABC,  1, 0, 3,   'h777,   0,         0, 3, 'hABC,   'h1111,  1, 0, 'h777,   0);
    vt[25] = mk(1, 0, 0, 0,      1, 0, 3,   'h777,   0,         1, 3, 'hABC,   'h1111,  0, 0, 'h777,   0);
    vt[26] = mk(1, 0, 0, 0,      0, 0, 3,   'h777,   0,         1, 3, 'hABC,   'h1111,  0, 0, 'h777,   1);
    vt[27] = mk(1, 0, 0, 0,      0, 0, 0,   0,       0,         1, 3, 'hABC,   'h1111,  0, 1, 'hABC,   1);
    vt[28] = mk(1, 0, 0, 0,      0, 0, 0,   0,       0,         1, 3, 'hABC,   'h1111,  0, 0, 'hABC,   1);

    for (int k = 0; k < 29; k++) begin
      rst_b = vt[k].rst_b; slot_en = vt[k].slot_en; vid_req = vt[k].vid_req;
      vid_addr = vt[k].vid_addr; cpu_req = vt[k].cpu_req; cpu_we = vt[k].cpu_we;
      cpu_be = vt[k].cpu_be; cpu_addr = vt[k].cpu_addr; cpu_wdata = vt[k].cpu_wdata;
      step();
      chk($sformatf("row%0d cs_b", k),    32'(mem_cs_b),    32'(vt[k].cs_b));
      chk($sformatf("row%0d we_b", k),    32'(mem_we_b),    32'(vt[k].we_b));
      chk($sformatf("row%0d addr", k),    32'(mem_addr),    32'(vt[k].addr));
      chk($sformatf("row%0d wdata", k),   32'(mem_wdata),   32'(vt[k].wdata));
      chk($sformatf("row%0d gnt", k),     32'(vid_gnt),     32'(vt[k].gnt));
      chk($sformatf("row%0d rvld", k),    32'(vid_rvld),    32'(vt[k].rvld));
      chk($sformatf("row%0d rdata", k),   32'(rdata),       32'(vt[k].rdata));
      chk($sformatf("row%0d dtack_b", k), 32'(cpu_dtack_b), 32'(vt[k].dtack_b));
      chk($sformatf("row%0d ovr", k),     32'(slot_ovr),    0);
    end

    // starvation: 8 video wins, 9th slot forced to CPU
    idle_inputs();
    vid_req = 1; cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 18'h321;
    step();
    for (int s = 0; s < 9; s++) begin
      slot_en = 1; vid_addr = 18'h400 + 18'(s);
      step();
      if (s < 8) begin
        chk($sformatf("starve slot%0d gnt", s), 32'(vid_gnt), 1);
        chk($sformatf("starve slot%0d addr", s), 32'(mem_addr), 32'h400 + 32'(s));
      end else begin
        chk("starve cpu gnt", 32'(vid_gnt), 0);
        chk("starve cpu cs_b", 32'(mem_cs_b), 0);
        chk("starve cpu addr", 32'(mem_addr), 32'h321);
      end
      slot_en = 0;
      step();
      if (s == 8) begin
        chk("starve rdata", 32'(rdata), 32'h321);
        chk("starve dtack_b", 32'(cpu_dtack_b), 0);
      end
      step(); step();
    end
    cpu_req = 0;
    step();
    chk("starve dtack release", 32'(cpu_dtack_b), 1);

    // abort while video owns the bus; video must still win (counter was cleared)
    cpu_addr = 18'h999; cpu_req = 1;
    step();
    slot_en = 1; vid_addr = 18'h500;
    step();
    chk("abort video gnt", 32'(vid_gnt), 1);
    slot_en = 0; cpu_req = 0;
    step();
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      slot_en = (i % 4 == 0); vid_addr = 18'h600 + 18'(i);
      step();
      if ((mem_cs_b == 1'b0 && mem_addr == 18'h999) || cpu_dtack_b !== 1'b1) bad++;
    end
    chk("abort no cpu access", 32'(bad), 0);

    // reset during C_BUSY of a CPU read
    idle_inputs();
    cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 18'h0C0;
    step();
    slot_en = 1;
    step();
    chk("rst issue cs_b", 32'(mem_cs_b), 0);
    slot_en = 0; rst_b = 0;
    step();
    chk("rst cs_b", 32'(mem_cs_b), 1);
    chk("rst we_b", 32'(mem_we_b), 3);
    chk("rst addr", 32'(mem_addr), 0);
    chk("rst wdata", 32'(mem_wdata), 0);
    chk("rst rdata", 32'(rdata), 0);
    chk("rst dtack_b", 32'(cpu_dtack_b), 1);
    chk("rst rvld", 32'(vid_rvld), 0);
    chk("rst gnt", 32'(vid_gnt), 0);
    chk("rst ovr", 32'(slot_ovr), 0);
    rst_b = 1; cpu_req = 0;
    step();
    chk("post rst dtack_b", 32'(cpu_dtack_b), 1);
    chk("post rst rvld", 32'(vid_rvld), 0);
    chk("post rst rdata", 32'(rdata), 0);
    cpu_req = 1; cpu_addr = 18'h0D0;
    step();
    slot_en = 1;
    step();
    chk("new cpu cs_b", 32'(mem_cs_b), 0);
    chk("new cpu addr", 32'(mem_addr), 32'h0D0);
    slot_en = 0;
    step();
    chk("new cpu rdata", 32'(rdata), 32'h0D0);
    chk("new cpu dtack_b", 32'(cpu_dtack_b), 0);
    cpu_req = 0;
    step();
    chk("new cpu dtack release", 32'(cpu_dtack_b), 1);

    // overrun on the MEM_LAT=3 instance with slot spacing 2
    idle_inputs();
    rst_b = 0;
    step();
    rst_b = 1;
    step();
    vid_req = 1; vid_addr = 18'h111; slot_en = 1;
    step();
    chk("ovr first cs_b", 32'(o_mem_cs_b), 0);
    chk("ovr first gnt", 32'(o_vid_gnt), 1);
    chk("ovr first addr", 32'(o_mem_addr), 32'h111);
    slot_en = 0;
    step();
    chk("ovr gap cs_b", 32'(o_mem_cs_b), 1);
    slot_en = 1; vid_addr = 18'h222;
    step();
    chk("ovr pulse", 32'(o_slot_ovr), 1);
    chk("ovr no gnt", 32'(o_vid_gnt), 0);
    chk("ovr no cs", 32'(o_mem_cs_b), 1);
    chk("ovr addr held", 32'(o_mem_addr), 32'h111);
    chk("lat1 no ovr", 32'(slot_ovr), 0);
    slot_en = 0;
    step();
    chk("ovr pulse end", 32'(o_slot_ovr), 0);
    chk("ovr rvld", 32'(o_vid_rvld), 1);
    chk("ovr rdata", 32'(o_rdata), 32'h111);
    chk("ovr cs idle", 32'(o_mem_cs_b), 1);
    slot_en = 1; vid_addr = 18'h333;
    step();
    chk("ovr next cs_b", 32'(o_mem_cs_b), 0);
    chk("ovr next addr", 32'(o_mem_addr), 32'h333);
    chk("ovr next no pulse", 32'(o_slot_ovr), 0);
    slot_en = 0; vid_req = 0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
